feature_mem_writer: RTL
=======================

Name: feature_mem_writer

Overview:
Write-side companion to the feature-memory address sweeper. It accepts a valid/ready stream of data words and writes them to consecutive memory addresses, starting at 0 and ending at a programmed last address. It signals completion so the read-side sweep can be triggered afterwards. It sits between the host/loader interface and the single-port feature/stage memory write port.

Parameters:
DATA_WIDTH, 8, width of each data word and of o_wr_data
ADDR_WIDTH, 12, width of write address and i_last_addr

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low reset (0 = reset)
i_start  input  1  single-cycle pulse that begins a load; honoured only in IDLE
i_abort  input  1  terminates an in-progress load; no done pulse is produced
i_last_addr  input  ADDR_WIDTH  final address to write; sampled on an accepted i_start
i_data  input  DATA_WIDTH  stream data
i_valid  input  1  i_data valid
o_ready  output  1  writer can accept a word this cycle
o_wr_en  output  1  memory write strobe
o_wr_address  output  ADDR_WIDTH  memory write address
o_wr_data  output  DATA_WIDTH  memory write data
o_busy  output  1  high from the cycle after an accepted start until return to IDLE
o_done  output  1  one-cycle pulse after the final word is written

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; address counter=0; latched last=0; all outputs 0.
- States: IDLE, WRITE, DONE.
- IDLE:
  - o_ready=0.
  - i_start=1 -> latch i_last_addr, set address counter to 0, go to WRITE.
  - i_valid is ignored in IDLE.
- WRITE:
  - o_ready=1.
  - Accept condition: i_valid & o_ready.
  - On accept, the next cycle drives o_wr_en=1, o_wr_address=current counter, o_wr_data=i_data. This is 1-cycle registered latency.
  - If counter != last: counter increments by 1 and the FSM stays in WRITE.
  - If counter == last: go to DONE. o_ready is 0 from the next cycle, so exactly (last+1) words are accepted.
- DONE: o_done=1 for exactly one cycle, coinciding with o_wr_en of the final word. Then go to IDLE with the counter cleared to 0.
- o_wr_en is 0 in every cycle with no accept in the previous cycle. Bubbles on i_valid are allowed, and the address does not advance on bubbles.
- Boundary rules:
  - i_last_addr=0: a single word is written to address 0.
  - i_last_addr=2^ADDR_WIDTH-1: the counter reaches the all-ones value without wrapping, and the load ends there.
  - i_start while busy is ignored; the latched last value is unchanged.
  - i_abort in WRITE: go to IDLE next cycle, counter cleared, no o_done.
    - Words already accepted still complete their o_wr_en cycle.
    - An accept in the same cycle as i_abort is dropped: no write is issued for it.
  - i_abort in IDLE or DONE has no effect; the DONE pulse still occurs.
  - i_start and i_abort together in IDLE: start wins.
  - Reset asserted mid-load: immediate return to the reset state. The memory contents written so far are unspecified/partial.
- Arithmetic:
  - The counter compare is an ADDR_WIDTH-bit equality against the latched last value.
  - The increment is unsigned, and no wrap is possible because the FSM terminates at last.

Optional Feature:
Macro FEATURE_MEM_WRITER_CHECKSUM_EN.
- When defined: adds output o_checksum [DATA_WIDTH-1:0].
  - Modulo-2^DATA_WIDTH sum of every word written in the current or most recent load.
  - Cleared to 0 on an accepted i_start and on reset.
  - Updated together with o_wr_en, so it is final in the o_done cycle.
  - Held after DONE until the next start. After an abort it keeps the partial sum.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package (feature_mem_pkg): state encoding constants IDLE=0, WRITE=1, DONE=2; STATE_SIZE=2; default DATA_WIDTH/ADDR_WIDTH constants. The read-side sweeper uses the same package.
- One natural sub-module, feature_mem_addr_ctr:
  - Ports: clear, enable, last, addr, at_last.
  - Pure counter with equality flag, reusable by the read side.

Test Plan:
1. Start with i_last_addr=3, i_valid held 1, data A0..A3 -> writes (0,A0),(1,A1),(2,A2),(3,A3) on consecutive cycles; o_done in the cycle of the addr-3 write; o_ready=0 afterwards.
2. Start with last=0, single word 5A -> exactly one write (0,5A) with o_done; a second valid word is not accepted.
3. last=4, i_valid toggling 1,0,1,0... -> addresses 0..4 in order with no gaps or repeats; o_wr_en only in cycles following an accept.
4. last=7, i_abort asserted together with the 3rd accepted word -> writes only to addresses 0,1; no o_done; o_busy=0 next cycle; a new start then writes from address 0.
5. i_start pulse mid-load with a different i_last_addr -> ignored; the load ends at the original last. Reset pulsed low mid-load -> all outputs 0 asynchronously.
6. With FEATURE_MEM_WRITER_CHECKSUM_EN, last=2, data FF,02,03 -> o_checksum=04 at o_done; the next start clears it to 00.

Source files
------------

// File: rtl/feature_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : feature_mem_pkg
// Description : Shared definitions for the feature-memory write path and the
//               read-side address sweeper: the state encoding and the default
//               data and address widths.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Contents    : STATE_SIZE, DEFAULT_DATA_WIDTH, DEFAULT_ADDR_WIDTH, state_t
// ============================================================================
package feature_mem_pkg;

  localparam int STATE_SIZE         = 2;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 12;

  typedef enum logic [STATE_SIZE-1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : feature_mem_pkg
`default_nettype wire

// File: rtl/feature_mem_writer_if.sv
`default_nettype none
// ============================================================================
// Interface   : feature_mem_writer_if
// Description : Host-side load stream, control and memory write-port bundle
//               for feature_mem_writer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Modports    : master - loader side (drives i_*, observes o_*)
//               slave  - writer side (observes i_*, drives o_*)
// Signals     : i_start, i_abort, i_last_addr, i_data, i_valid,
//               o_ready, o_wr_en, o_wr_address, o_wr_data, o_busy, o_done,
//               o_checksum (only with FEATURE_MEM_WRITER_CHECKSUM_EN)
// Macro       : FEATURE_MEM_WRITER_CHECKSUM_EN adds o_checksum
// ============================================================================
interface feature_mem_writer_if #(
  parameter int DATA_WIDTH = feature_mem_pkg::DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = feature_mem_pkg::DEFAULT_ADDR_WIDTH
);

  logic                  i_start;
  logic                  i_abort;
  logic [ADDR_WIDTH-1:0] i_last_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic                  o_ready;
  logic                  o_wr_en;
  logic [ADDR_WIDTH-1:0] o_wr_address;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  o_busy;
  logic                  o_done;
`ifdef FEATURE_MEM_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] o_checksum;

  modport master (
    output i_start, i_abort, i_last_addr, i_data, i_valid,
    input  o_ready, o_wr_en, o_wr_address, o_wr_data, o_busy, o_done,
           o_checksum
  );

  modport slave (
    input  i_start, i_abort, i_last_addr, i_data, i_valid,
    output o_ready, o_wr_en, o_wr_address, o_wr_data, o_busy, o_done,
           o_checksum
  );
`else
  modport master (
    output i_start, i_abort, i_last_addr, i_data, i_valid,
    input  o_ready, o_wr_en, o_wr_address, o_wr_data, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_last_addr, i_data, i_valid,
    output o_ready, o_wr_en, o_wr_address, o_wr_data, o_busy, o_done
  );
`endif

endinterface : feature_mem_writer_if
`default_nettype wire

// File: rtl/feature_mem_addr_ctr.sv
`default_nettype none
// ============================================================================
// Module      : feature_mem_addr_ctr
// Description : Address counter with an equality flag against a terminal
//               address. Shared by the write and read sides of the feature
//               memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk     - system clock
//               reset   - asynchronous active-low reset
//               clear   - synchronous clear to address 0 (priority)
//               enable  - advance by one (held once addr equals last)
//               last    - terminal address
//               addr    - current address
//               at_last - addr == last
// ============================================================================
module feature_mem_addr_ctr
  import feature_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] last,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  at_last
);

  localparam logic [ADDR_WIDTH-1:0] C_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  w_at_last;

  assign w_at_last = (r_addr == last);

  // Holding at the terminal address means an all-ones terminal never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
    end else if (clear) begin
      r_addr <= '0;
    end else if (enable && !w_at_last) begin
      r_addr <= r_addr + C_ONE;
    end
  end

  assign addr    = r_addr;
  assign at_last = w_at_last;

endmodule : feature_mem_addr_ctr
`default_nettype wire

// File: rtl/feature_mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : feature_mem_writer
// Description : Accepts a valid/ready word stream and writes it to addresses
//               0..last of the feature memory, then pulses o_done so the
//               read-side sweep can start.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk   - system clock
//               reset - asynchronous active-low reset
//               bus   - feature_mem_writer_if.slave:
//                 i_start/i_abort/i_last_addr   load control
//                 i_data/i_valid/o_ready        input stream
//                 o_wr_en/o_wr_address/o_wr_data memory write port
//                 o_busy/o_done                 status
//                 o_checksum                    running sum (optional)
// Macro       : FEATURE_MEM_WRITER_CHECKSUM_EN enables o_checksum
// ============================================================================
module feature_mem_writer
  import feature_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  feature_mem_writer_if.slave  bus
);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_at_last;
  logic                  w_ready;
  logic                  w_start_ok;
  logic                  w_ctr_clear;
  logic                  w_write;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_address;
  logic [DATA_WIDTH-1:0] r_wr_data;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_start_ok   = 1'b0;
    w_ctr_clear  = 1'b0;
    w_write      = 1'b0;
    case (r_state)
      IDLE: begin
        // Abort is meaningless here, so a coincident start simply wins.
        if (bus.i_start) begin
          w_start_ok   = 1'b1;
          w_ctr_clear  = 1'b1;
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        w_ready = 1'b1;
        // Abort takes precedence over a same-cycle accept: that word is dropped.
        if (bus.i_abort) begin
          w_ctr_clear  = 1'b1;
          w_state_next = IDLE;
        end else if (bus.i_valid) begin
          w_write = 1'b1;
          if (w_at_last) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_ctr_clear  = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_ctr_clear  = 1'b1;
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address counter
  // --------------------------------------------------------------------------
  feature_mem_addr_ctr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_ctr_clear),
    .enable  (w_write),
    .last    (r_last),
    .addr    (w_addr),
    .at_last (w_at_last)
  );

  // --------------------------------------------------------------------------
  // Latched terminal address and registered write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last       <= '0;
      r_wr_en      <= 1'b0;
      r_wr_address <= '0;
      r_wr_data    <= '0;
    end else begin
      if (w_start_ok) begin
        r_last <= bus.i_last_addr;
      end
      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_address <= w_addr;
        r_wr_data    <= bus.i_data;
      end
    end
  end

`ifdef FEATURE_MEM_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  // Advances on the same edge that raises o_wr_en, so it is final with o_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_write) begin
      r_checksum <= r_checksum + bus.i_data;
    end
  end

  assign bus.o_checksum = r_checksum;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // DONE is entered on the final accept, so o_done lines up with its write.
  assign bus.o_ready      = w_ready;
  assign bus.o_wr_en      = r_wr_en;
  assign bus.o_wr_address = r_wr_address;
  assign bus.o_wr_data    = r_wr_data;
  assign bus.o_busy       = (r_state != IDLE);
  assign bus.o_done       = (r_state == DONE);

endmodule : feature_mem_writer
`default_nettype wire
